// File: rtl/regfile_ext_alu.sv
// regfile_ext_alu: 32x32 register file (x0 hard-wired to zero), RISC-V style
// immediate extender (I/S/B/J) and a small combinational ALU.
// Optional feature macro: REGFILE_BYPASS_EN. When defined, a write in flight
// is forwarded to a read port addressing the same register in the same cycle.
// When undefined, reads return stored contents only.
module regfile_ext_alu #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [4:0]        A1,
    input  logic [4:0]        A2,
    input  logic [4:0]        A3,
    input  logic [DATA_W-1:0] WD3,
    input  logic              WE3,
    input  logic [24:0]       immValue,
    input  logic [1:0]        immSrc,
    input  logic              ALUSrc,
    input  logic [2:0]        ALUControl,
    output logic [DATA_W-1:0] RD1,
    output logic [DATA_W-1:0] RD2,
    output logic [DATA_W-1:0] immExt,
    output logic [DATA_W-1:0] ALUResult,
    output logic              Zero
);

    logic [DATA_W-1:0] regs [0:31];
    logic [DATA_W-1:0] stored1;
    logic [DATA_W-1:0] stored2;
    logic [DATA_W-1:0] src_b;

    // ALU operation; slt compares as two's complement, shifts use srcB[4:0].
    function automatic logic [DATA_W-1:0] alu_op(
        input logic [2:0]               op,
        input logic signed [DATA_W-1:0] a,
        input logic signed [DATA_W-1:0] b
    );
        logic [DATA_W-1:0] r;
        case (op)
            3'b000:  r = a + b;
            3'b001:  r = a - b;
            3'b010:  r = a & b;
            3'b011:  r = a | b;
            3'b100:  r = a ^ b;
            3'b101:  r = {{(DATA_W-1){1'b0}}, (a < b)};
            3'b110:  r = $unsigned(a) << b[4:0];
            3'b111:  r = $unsigned(a) >> b[4:0];
            default: r = '0;
        endcase
        return r;
    endfunction

    // Register storage: reset clears everything and blocks the write; x0 is never written.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (WE3 && (A3 != 5'd0)) begin
            regs[A3] <= WD3;
        end
    end

    // Stored read values; x0 is forced to zero regardless of array content.
    always_comb begin
        stored1 = (A1 == 5'd0) ? '0 : regs[A1];
        stored2 = (A2 == 5'd0) ? '0 : regs[A2];
    end

`ifdef REGFILE_BYPASS_EN
    logic wr_live;
    assign wr_live = WE3 && !reset && (A3 != 5'd0);

    // Write-through: a live write is visible on matching read ports before the edge.
    always_comb begin
        RD1 = (wr_live && (A1 == A3)) ? WD3 : stored1;
        RD2 = (wr_live && (A2 == A3)) ? WD3 : stored2;
    end
`else
    // Reads see only what is already stored; a same-cycle write appears after the edge.
    always_comb begin
        RD1 = stored1;
        RD2 = stored2;
    end
`endif

    // Immediate extension; the sign bit is always instr[31] = immValue[24].
    always_comb begin
        case (immSrc)
            2'b00:   immExt = {{(DATA_W-12){immValue[24]}}, immValue[24:13]};
            2'b01:   immExt = {{(DATA_W-12){immValue[24]}}, immValue[24:18], immValue[4:0]};
            2'b10:   immExt = {{(DATA_W-12){immValue[24]}}, immValue[0], immValue[23:18],
                               immValue[4:1], 1'b0};
            2'b11:   immExt = {{(DATA_W-20){immValue[24]}}, immValue[12:5], immValue[13],
                               immValue[23:14], 1'b0};
            default: immExt = '0;
        endcase
    end

    // ALU datapath and zero flag.
    always_comb begin
        src_b     = ALUSrc ? immExt : RD2;
        ALUResult = alu_op(ALUControl, RD1, src_b);
        Zero      = (ALUResult == '0);
    end

endmodule

// File: tb/tb_regfile_ext_alu.sv
// tb_regfile_ext_alu: directed and randomized checks of regfile_ext_alu
// against an instruction-level reference model kept in the bench.
module tb_regfile_ext_alu;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  A1, A2, A3;
    logic [31:0] WD3;
    logic        WE3;
    logic [24:0] immValue;
    logic [1:0]  immSrc;
    logic        ALUSrc;
    logic [2:0]  ALUControl;
    logic [31:0] RD1, RD2, immExt, ALUResult;
    logic        Zero;

    int checks = 0;
    int errors = 0;
    logic [31:0] mregs [0:31];

    regfile_ext_alu dut (
        .clk(clk), .reset(reset), .A1(A1), .A2(A2), .A3(A3), .WD3(WD3), .WE3(WE3),
        .immValue(immValue), .immSrc(immSrc), .ALUSrc(ALUSrc), .ALUControl(ALUControl),
        .RD1(RD1), .RD2(RD2), .immExt(immExt), .ALUResult(ALUResult), .Zero(Zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Read as the architecture defines it, including optional forwarding.
    function automatic logic [31:0] ref_read(input logic [4:0] idx);
        if (idx == 5'd0) return 32'd0;
`ifdef REGFILE_BYPASS_EN
        if (WE3 && !reset && (A3 != 5'd0) && (idx == A3)) return WD3;
`endif
        return mregs[idx];
    endfunction

    // Immediate rebuilt from the full 32-bit instruction word, RISC-V field layout.
    function automatic logic [31:0] ref_imm(input logic [24:0] v, input logic [1:0] s);
        logic [31:0] ins;
        int          val;
        ins = {v, 7'b0};
        case (s)
            2'b00: val = $signed(ins) >>> 20;
            2'b01: val = (($signed(ins) >>> 25) * 32) + int'(ins[11:7]);
            2'b10: val = (($signed(ins) >>> 31) * 4096) + int'(ins[7]) * 2048
                         + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2;
            default: val = (($signed(ins) >>> 31) * 1048576) + int'(ins[19:12]) * 4096
                         + int'(ins[20]) * 2048 + int'(ins[30:21]) * 2;
        endcase
        return val;
    endfunction

    function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        int sa, sb;
        sa = a;
        sb = b;
        case (op)
            3'b000: return a + b;
            3'b001: return a - b;
            3'b010: return a & b;
            3'b011: return a | b;
            3'b100: return a ^ b;
            3'b101: return (sa < sb) ? 32'd1 : 32'd0;
            3'b110: return a << (b % 32);
            default: return a >> (b % 32);
        endcase
    endfunction

    // Drive a full input vector at the falling edge, then compare every output.
    task automatic apply(input logic rst, input logic we, input logic [4:0] a1,
                         input logic [4:0] a2, input logic [4:0] a3, input logic [31:0] wd,
                         input logic [24:0] iv, input logic [1:0] is, input logic as,
                         input logic [2:0] op);
        logic [31:0] r1, r2, im, res;
        @(negedge clk);
        reset = rst; WE3 = we; A1 = a1; A2 = a2; A3 = a3; WD3 = wd;
        immValue = iv; immSrc = is; ALUSrc = as; ALUControl = op;
        #1;
        r1  = ref_read(a1);
        r2  = ref_read(a2);
        im  = ref_imm(iv, is);
        res = ref_alu(op, r1, as ? im : r2);
        chk("rd1", RD1, r1);
        chk("rd2", RD2, r2);
        chk("immext", immExt, im);
        chk("aluresult", ALUResult, res);
        chk("zero", {31'd0, Zero}, {31'd0, res == 32'd0});
    endtask

    // Take the rising edge and update the architectural state.
    task automatic tick();
        @(posedge clk);
        if (reset) begin
            for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
        end else if (WE3 && A3 != 5'd0) begin
            mregs[A3] = WD3;
        end
    endtask

    initial begin
        // Initial reset: contents are unknown until the first reset edge.
        reset = 1'b1; WE3 = 1'b1; A1 = 0; A2 = 0; A3 = 5'd3; WD3 = 32'h1234;
        immValue = 0; immSrc = 0; ALUSrc = 0; ALUControl = 0;
        for (int i = 0; i < 32; i++) mregs[i] = 32'hx;
        tick();

        // Reset state: every index reads zero, all-zero add gives Zero=1.
        apply(0, 0, 5'd3, 5'd31, 0, 0, 0, 0, 0, 3'b000);
        chk("rst_rd1", RD1, 32'd0);
        chk("rst_rd2", RD2, 32'd0);
        chk("rst_zero", {31'd0, Zero}, 32'd1);
        tick();

        // Write x2 = 30, then read on both ports.
        apply(0, 1, 0, 0, 5'd2, 32'd30, 0, 0, 0, 3'b000);
        tick();
        apply(0, 0, 5'd2, 5'd2, 0, 0, 0, 0, 0, 3'b000);
        chk("x2_rd1", RD1, 32'd30);
        chk("x2_rd2", RD2, 32'd30);
        tick();

        // Writes to x0 are dropped.
        apply(0, 1, 0, 0, 5'd0, 32'hDEADBEEF, 0, 0, 0, 3'b000);
        tick();
        apply(0, 0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 3'b000);
        chk("x0_rd1", RD1, 32'd0);
        tick();

        // I-immediate 15: add and and with x2.
        apply(0, 0, 5'd2, 5'd2, 0, 0, 25'(15) << 13, 2'b00, 1, 3'b000);
        chk("i15_imm", immExt, 32'd15);
        chk("i15_add", ALUResult, 32'd45);
        chk("i15_zero", {31'd0, Zero}, 32'd0);
        tick();
        apply(0, 0, 5'd2, 5'd2, 0, 0, 25'(15) << 13, 2'b00, 1, 3'b010);
        chk("i15_and", ALUResult, 32'd14);
        tick();

        // I-immediate -1: slt false, sub wraps to 31.
        apply(0, 0, 5'd2, 5'd2, 0, 0, {12'hFFF, 13'd0}, 2'b00, 1, 3'b101);
        chk("im1_imm", immExt, 32'hFFFFFFFF);
        chk("im1_slt", ALUResult, 32'd0);
        tick();
        apply(0, 0, 5'd2, 5'd2, 0, 0, {12'hFFF, 13'd0}, 2'b00, 1, 3'b001);
        chk("im1_sub", ALUResult, 32'd31);
        tick();

        // Register-register sub to zero; S-format immediate -2.
        apply(0, 0, 5'd2, 5'd2, 0, 0, {7'h7F, 13'd0, 5'h1E}, 2'b01, 0, 3'b001);
        chk("rr_sub", ALUResult, 32'd0);
        chk("rr_zero", {31'd0, Zero}, 32'd1);
        chk("s_imm", immExt, 32'hFFFFFFFE);
        tick();

        // Same-cycle write and read of x5.
        apply(0, 1, 5'd5, 5'd0, 5'd5, 32'd7, 0, 0, 0, 3'b000);
`ifdef REGFILE_BYPASS_EN
        chk("bypass_rd1", RD1, 32'd7);
`else
        chk("nobypass_rd1", RD1, 32'd0);
`endif
        tick();
        apply(0, 0, 5'd5, 5'd0, 0, 0, 0, 0, 0, 3'b000);
        chk("x5_after", RD1, 32'd7);
        tick();

        // Reset mid-sequence discards the pending write and clears x2, x5.
        apply(1, 1, 5'd2, 5'd5, 5'd9, 32'h55AA, 0, 0, 0, 3'b000);
        tick();
        apply(0, 0, 5'd9, 5'd5, 0, 0, 0, 0, 0, 3'b000);
        chk("rst_x9", RD1, 32'd0);
        chk("rst_x5", RD2, 32'd0);
        tick();

        // Randomized traffic with occasional resets and forced address collisions.
        for (int n = 0; n < 400; n++) begin
            logic [4:0] a1, a2, a3;
            a3 = 5'($urandom_range(0, 31));
            a1 = ($urandom_range(0, 3) == 0) ? a3 : 5'($urandom_range(0, 31));
            a2 = ($urandom_range(0, 3) == 0) ? a3 : 5'($urandom_range(0, 31));
            apply(($urandom_range(0, 29) == 0), 1'($urandom), a1, a2, a3,
                  ($urandom_range(0, 7) == 0) ? 32'($urandom_range(0, 40)) : $urandom,
                  25'($urandom), 2'($urandom), 1'($urandom), 3'($urandom));
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_ext_alu.md
REGFILE_EXT_ALU -- requirements
Module: regfile_ext_alu

Interface
REQ-001 SHALL have `clk`, input, 1 bit: single clock; all state updates on rising edge.
REQ-002 SHALL have `reset`, input, 1 bit: reset is synchronous and active-high.
REQ-003 SHALL have `A1`, input, 5 bits: read-port-1 register index.
REQ-004 SHALL have `A2`, input, 5 bits: read-port-2 register index.
REQ-005 SHALL have `A3`, input, 5 bits: write-port register index.
REQ-006 SHALL have `WD3`, input, 32 bits: write data.
REQ-007 SHALL have `WE3`, input, 1 bit: write enable.
REQ-008 SHALL have `immValue`, input, 25 bits: instruction bits [31:7], so immValue[k] = instr[k+7].
REQ-009 SHALL have `immSrc`, input, 2 bits: immediate format; 00 I, 01 S, 10 B, 11 J.
REQ-010 SHALL have `ALUSrc`, input, 1 bit: ALU operand-B select; 0 RD2, 1 immExt.
REQ-011 SHALL have `ALUControl`, input, 3 bits: ALU operation select.
REQ-012 SHALL have `RD1`, output, 32 bits, and `RD2`, output, 32 bits: read data.
REQ-013 SHALL have `immExt`, output, 32 bits: sign-extended immediate.
REQ-014 SHALL have `ALUResult`, output, 32 bits, and `Zero`, output, 1 bit: ALU result and zero flag.

Function
REQ-015 SHALL contain a 32x32-bit register file with synchronous write: on a `clk` rising edge with `WE3`=1 and `reset`=0, regs[A3] <= WD3.
REQ-016 Register x0 SHALL always read 0; writes with A3=0 SHALL be discarded.
REQ-017 RD1/RD2 SHALL be combinational reads of regs[A1]/regs[A2]; both ports may address the same register.
REQ-018 immExt SHALL be combinational, with sign taken from immValue[24]:
- I: sext(immValue[24:13]).
- S: sext({immValue[24:18], immValue[4:0]}).
- B: sext({immValue[24], immValue[0], immValue[23:18], immValue[4:1], 1'b0}).
- J: sext({immValue[24], immValue[12:5], immValue[13], immValue[23:14], 1'b0}).
REQ-019 The ALU SHALL be combinational with srcA=RD1 and srcB = ALUSrc ? immExt : RD2.
REQ-020 ALUControl operations SHALL be:
- 000 add; 001 sub; 010 and; 011 or; 100 xor.
- 101 slt (signed, result 1/0).
- 110 sll by srcB[4:0]; 111 srl (logical) by srcB[4:0].
REQ-021 Add/sub SHALL wrap modulo 2^32; no carry or overflow output.
REQ-022 Zero SHALL be 1 iff ALUResult==32'd0.
REQ-023 A write and a read of the same register in one cycle SHALL read the old value until the edge, unless REQ-028 applies.

Reset
REQ-024 On a `clk` rising edge with `reset`=1, all 32 registers SHALL clear to 0, and WE3 SHALL be ignored that cycle.
REQ-025 After reset, RD1=RD2=0 for any index; ALUResult/immExt SHALL follow their inputs combinationally (e.g. all-zero inputs with ALUSrc=0 and add give ALUResult=0, Zero=1).
REQ-026 Reset asserted mid-sequence SHALL discard any pending write on that edge; no other state exists.

Configuration
REQ-027 Macro REGFILE_BYPASS_EN SHALL control write-through forwarding.
REQ-028 When REGFILE_BYPASS_EN is defined: if WE3=1, reset=0, A3!=0 and A1 (or A2)==A3, then RD1 (or RD2) SHALL equal WD3 in the same cycle.
REQ-029 When REGFILE_BYPASS_EN is undefined: reads SHALL return stored contents only.

Verification
REQ-030 Reset, then write x2=30 (A3=2, WE3=1, one edge); A1=A2=2 -> RD1=RD2=30.
REQ-031 Write x0=0xDEADBEEF; A1=0 -> RD1=0.
REQ-032 x2=30, immSrc=00, immValue=15<<13, ALUSrc=1, ALUControl=000 -> immExt=15, ALUResult=45, Zero=0; with ALUControl=010 -> ALUResult=14.
REQ-033 immSrc=00, immValue[24:13]=0xFFF -> immExt=0xFFFFFFFF; x2=30 with ALUControl=101 -> ALUResult=0 (30 < -1 is false); with ALUControl=001 -> ALUResult=31.
REQ-034 A1=A2=2, ALUSrc=0, ALUControl=001 -> ALUResult=0, Zero=1; S-format immValue[24:18]=7'h7F, immValue[4:0]=5'h1E -> immExt=0xFFFFFFFE.
REQ-035 With WE3=1, A3=A1=5, WD3=7, before the edge: RD1=7 if REGFILE_BYPASS_EN is defined, else RD1=old value 0.
